// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and grant source.
package mem_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 3'd0;
  localparam arb_state_t ST_IC_REQ  = 3'd1;
  localparam arb_state_t ST_IC_WAIT = 3'd2;
  localparam arb_state_t ST_DC_REQ  = 3'd3;
  localparam arb_state_t ST_DC_WAIT = 3'd4;

  typedef enum logic {
    GRANT_IC = 1'b0,
    GRANT_DC = 1'b1
  } grant_src_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache refill, D-side access and backing-memory signals around the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  ic_req_i;
  logic [ADDR_WIDTH-1:0] ic_addr_i;
  logic                  ic_gnt_o;
  logic                  ic_rvalid_o;
  logic [DATA_WIDTH-1:0] ic_rdata_o;
  logic                  ic_done_o;
  logic                  ic_busy_o;

  logic                  dc_req_i;
  logic                  dc_we_i;
  logic [ADDR_WIDTH-1:0] dc_addr_i;
  logic [DATA_WIDTH-1:0] dc_wdata_i;
  logic [STRB_WIDTH-1:0] dc_wstrb_i;
  logic                  dc_gnt_o;
  logic                  dc_rvalid_o;
  logic [DATA_WIDTH-1:0] dc_rdata_o;
  logic                  dc_busy_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [STRB_WIDTH-1:0] mem_wstrb_o;
  logic                  mem_ready_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  // The arbiter masters the memory port, so it takes the master view.
  modport master (
    input  ic_req_i, ic_addr_i,
    input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i, dc_wstrb_i,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output ic_gnt_o, ic_rvalid_o, ic_rdata_o, ic_done_o, ic_busy_o,
    output dc_gnt_o, dc_rvalid_o, dc_rdata_o, dc_busy_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  modport slave (
    output ic_req_i, ic_addr_i,
    output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i, dc_wstrb_i,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  ic_gnt_o, ic_rvalid_o, ic_rdata_o, ic_done_o, ic_busy_o,
    input  dc_gnt_o, dc_rvalid_o, dc_rdata_o, dc_busy_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side not granted last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0]  req,
  input  grant_src_t  last,
  output grant_src_t  pick,
  output logic        valid
);

  // req[0] is the I-cache, req[1] the D-side.
  always_comb begin
    valid = |req;
    pick  = GRANT_IC;
    if (req == 2'b11) begin
      pick = (last == GRANT_IC) ? GRANT_DC : GRANT_IC;
    end else if (req[1]) begin
      pick = GRANT_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache line refills and single-word D-side accesses,
// one transaction outstanding at a time; return data is forwarded with no added latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  mem_arbiter_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_BITS  = $clog2(LINE_WORDS);
  localparam int BYTE_BITS  = $clog2(STRB_WIDTH);
  localparam int LINE_BITS  = BEAT_BITS + BYTE_BITS;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << LINE_BITS) - ADDR_WIDTH'(1));
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);

  arb_state_t            state;
  logic [BEAT_BITS-1:0]  beat_cnt;
  grant_src_t            last_grant;
  logic                  ic_gnt_q;
  logic                  dc_gnt_q;
  logic [ADDR_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0] dc_addr_q;
  logic [DATA_WIDTH-1:0] dc_wdata_q;
  logic [STRB_WIDTH-1:0] dc_wstrb_q;
  logic                  dc_we_q;

  grant_src_t            pick;
  logic                  pick_valid;
  logic                  ic_active;
  logic                  dc_active;
  logic [ADDR_WIDTH-1:0] ic_beat_addr;

  rr_pick2 u_pick (
    .req   ({bus.dc_req_i, bus.ic_req_i}),
    .last  (last_grant),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Beat offset is OR-ed into the line base so a burst can never carry into the next line.
  assign ic_beat_addr = line_q | (ADDR_WIDTH'(beat_cnt) << BYTE_BITS);
  assign ic_active    = (state == ST_IC_REQ) || (state == ST_IC_WAIT);
  assign dc_active    = (state == ST_DC_REQ) || (state == ST_DC_WAIT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      last_grant <= GRANT_IC;
      ic_gnt_q   <= 1'b0;
      dc_gnt_q   <= 1'b0;
      line_q     <= '0;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
      dc_wstrb_q <= '0;
      dc_we_q    <= 1'b0;
    end else begin
      ic_gnt_q <= 1'b0;
      dc_gnt_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            last_grant <= pick;
            if (pick == GRANT_IC) begin
              state    <= ST_IC_REQ;
              ic_gnt_q <= 1'b1;
              line_q   <= bus.ic_addr_i & LINE_MASK;
              beat_cnt <= '0;
            end else begin
              state      <= ST_DC_REQ;
              dc_gnt_q   <= 1'b1;
              dc_addr_q  <= bus.dc_addr_i;
              dc_wdata_q <= bus.dc_wdata_i;
              dc_wstrb_q <= bus.dc_wstrb_i;
              dc_we_q    <= bus.dc_we_i;
            end
          end
        end
        ST_IC_REQ: begin
          if (bus.mem_ready_i) state <= ST_IC_WAIT;
        end
        ST_IC_WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              state    <= ST_IC_REQ;
            end
          end
        end
        ST_DC_REQ: begin
          if (bus.mem_ready_i) state <= ST_DC_WAIT;
        end
        ST_DC_WAIT: begin
          if (bus.mem_rvalid_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ic_gnt_o    = ic_gnt_q;
  assign bus.dc_gnt_o    = dc_gnt_q;
  assign bus.ic_busy_o   = bus.ic_req_i | ic_active;
  assign bus.dc_busy_o   = bus.dc_req_i | dc_active;

  // Return path is gated purely by state so stray memory responses never reach a client.
  assign bus.ic_rvalid_o = (state == ST_IC_WAIT) && bus.mem_rvalid_i;
  assign bus.ic_done_o   = bus.ic_rvalid_o && (beat_cnt == LAST_BEAT);
  assign bus.ic_rdata_o  = bus.ic_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.dc_rvalid_o = (state == ST_DC_WAIT) && bus.mem_rvalid_i;
  assign bus.dc_rdata_o  = bus.dc_rvalid_o ? bus.mem_rdata_i : '0;

  assign bus.mem_req_o   = (state == ST_IC_REQ) || (state == ST_DC_REQ);
  assign bus.mem_we_o    = (state == ST_DC_REQ) && dc_we_q;
  assign bus.mem_addr_o  = (state == ST_IC_REQ) ? ic_beat_addr :
                           (state == ST_DC_REQ) ? dc_addr_q : '0;
  assign bus.mem_wdata_o = (state == ST_DC_REQ) ? dc_wdata_q : '0;
  assign bus.mem_wstrb_o = (state == ST_DC_REQ) ? dc_wstrb_q : '0;

endmodule
